// File: rtl/food_ctrl_pkg.sv
// Shared game package: game_status encodings, playfield limits
// and the food controller state type.
package food_ctrl_pkg;

  localparam logic [1:0] GS_RESTART = 2'b00;
  localparam logic [1:0] GS_PLAY    = 2'b10;

  localparam int X_MAX = 75;
  localparam int Y_MAX = 58;

  typedef enum logic [1:0] {
    S_CLEAR,
    S_ACTIVE,
    S_EAT,
    S_GEN
  } food_state_e;

endpackage

// File: rtl/food_ctrl_if.sv
// Food controller bus: game_status/head/scan in, apple/score out.
// master = game side, slave = food_ctrl.
interface food_ctrl_if;
  logic [1:0]  game_status;
  logic [6:0]  head_x;
  logic [6:0]  head_y;
  logic [9:0]  x_pos;
  logic [9:0]  y_pos;
  logic        add_cube;
  logic [6:0]  apple_x;
  logic [6:0]  apple_y;
  logic        apple_pix;
  logic [15:0] score;

  modport master (
    output game_status, head_x, head_y, x_pos, y_pos,
    input  add_cube, apple_x, apple_y, apple_pix, score
  );

  modport slave (
    input  game_status, head_x, head_y, x_pos, y_pos,
    output add_cube, apple_x, apple_y, apple_pix, score
  );
endinterface

// File: rtl/food_ctrl_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11.
// Ports: clk, rst (async low), seed (reset value), q (state).
module lfsr16 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic fb;
  assign fb = q[15] ^ q[13] ^ q[12] ^ q[10];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= seed;
    else      q <= {q[14:0], fb};
  end

endmodule

// File: rtl/food_ctrl.sv
// Apple placement, eat detection, BCD score and apple pixel.
// Ports: clk, rst (async low), food (food_ctrl_if.slave).
module food_ctrl
  import food_ctrl_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int X_MAX  = food_ctrl_pkg::X_MAX,
  parameter int Y_MAX  = food_ctrl_pkg::Y_MAX,
  parameter int INIT_X = 40,
  parameter int INIT_Y = 30
) (
  input logic          clk,
  input logic          rst,
  food_ctrl_if.slave   food
);

  localparam logic [6:0] XM = 7'(X_MAX);
  localparam logic [6:0] YM = 7'(Y_MAX);
  localparam logic [6:0] IX = 7'(INIT_X);
  localparam logic [6:0] IY = 7'(INIT_Y);

  function automatic logic [15:0] bcd_inc(
    input logic [15:0] v
  );
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    if (v != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (c) begin
          if (r[i*4 +: 4] == 4'd9) begin
            r[i*4 +: 4] = 4'd0;
          end else begin
            r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  food_state_e state;
  logic [15:0] lfsr_q;
  logic [6:0]  ax, ay;
  logic [15:0] score_q;
  logic        add_q;

  lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (LFSR_SEED),
    .q    (lfsr_q)
  );

  logic [6:0] cx, cy;
  logic       cand_ok;
  logic       play, restart, hit;
  logic       lfsr_unused;

  assign cx = lfsr_q[6:0];
  assign cy = {1'b0, lfsr_q[13:8]};
  assign lfsr_unused = ^{lfsr_q[15:14], lfsr_q[7]};

  assign cand_ok = (cx >= 7'd1) && (cx <= XM)
                && (cy >= 7'd1) && (cy <= YM)
                && !((cx == food.head_x)
                  && (cy == food.head_y));

  assign play    = food.game_status == GS_PLAY;
  assign restart = food.game_status == GS_RESTART;
  assign hit     = (food.head_x == ax)
                && (food.head_y == ay);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_CLEAR;
      ax      <= IX;
      ay      <= IY;
      score_q <= 16'h0000;
      add_q   <= 1'b0;
    end else if (restart) begin
      state   <= S_CLEAR;
      ax      <= IX;
      ay      <= IY;
      score_q <= 16'h0000;
      add_q   <= 1'b0;
    end else begin
      unique case (state)
        S_CLEAR: begin
          add_q <= 1'b0;
          if (play) state <= S_ACTIVE;
        end
        S_ACTIVE: begin
          if (play && hit) begin
            state   <= S_EAT;
            add_q   <= 1'b1;
            score_q <= bcd_inc(score_q);
          end
        end
        S_EAT: begin
          add_q <= 1'b0;
          state <= S_GEN;
        end
        S_GEN: begin
          // retry every cycle until a legal cell
          if (cand_ok) begin
            ax    <= cx;
            ay    <= cy;
            state <= S_ACTIVE;
          end
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

  assign food.add_cube  = add_q;
  assign food.apple_x   = ax;
  assign food.apple_y   = ay;
  assign food.score     = score_q;
  assign food.apple_pix = (food.x_pos < 10'd640)
                       && (food.y_pos < 10'd480)
                       && (food.x_pos[9:3] == ax)
                       && (food.y_pos[9:3] == ay)
                       && (state != S_GEN);

endmodule

// File: tb/tb_food_ctrl.sv
// Self-checking bench for food_ctrl: directed table,
// corner sequences and random play against a reference model.
module tb_food_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  food_ctrl_if food ();

  food_ctrl dut (
    .clk  (clk),
    .rst  (rst),
    .food (food)
  );

  int n_vec = 0;
  int n_bad = 0;

  // reference model state
  logic [15:0] m_lfsr;
  logic [15:0] m_score;
  logic [6:0]  m_ax, m_ay;
  bit          m_add;
  bit          m_wait;
  bit          m_reloc;

  typedef struct {
    logic [1:0]  st;
    logic [6:0]  hx, hy;
    logic [9:0]  xp, yp;
    logic        add;
    logic [6:0]  ax, ay;
    logic        pix;
    logic [15:0] sc;
  } vec_t;

  vec_t tab[10];

  task automatic chk(input string name,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h @%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] bcd_next(
    input logic [15:0] v
  );
    int d;
    logic [15:0] r;
    d = v[15:12] * 1000 + v[11:8] * 100
      + v[7:4] * 10 + v[3:0];
    d = (d + 1 > 9999) ? 9999 : d + 1;
    r[15:12] = 4'(d / 1000);
    r[11:8]  = 4'((d / 100) % 10);
    r[7:4]   = 4'((d / 10) % 10);
    r[3:0]   = 4'(d % 10);
    return r;
  endfunction

  task automatic model_reset();
    m_lfsr  = 16'hACE1;
    m_score = 16'h0000;
    m_ax    = 7'd40;
    m_ay    = 7'd30;
    m_add   = 1'b0;
    m_wait  = 1'b1;
    m_reloc = 1'b0;
  endtask

  function automatic bit cand_legal(input logic [15:0] l,
                                    input logic [6:0] hx,
                                    input logic [6:0] hy);
    int cx, cy;
    cx = int'(l) % 128;
    cy = (int'(l) / 256) % 64;
    return cx >= 1 && cx <= 75 && cy >= 1 && cy <= 58
        && !(cx == int'(hx) && cy == int'(hy));
  endfunction

  task automatic model_clock(input logic [1:0] st,
                             input logic [6:0] hx,
                             input logic [6:0] hy);
    logic [15:0] l;
    l = m_lfsr;
    m_lfsr = {l[14:0], ^(l & 16'hB400)};
    if (st == 2'b00) begin
      m_ax = 7'd40; m_ay = 7'd30;
      m_score = 16'h0000;
      m_add = 1'b0; m_wait = 1'b1; m_reloc = 1'b0;
    end else if (m_wait) begin
      if (st == 2'b10) m_wait = 1'b0;
    end else if (m_add) begin
      m_add = 1'b0;
      m_reloc = 1'b1;
    end else if (m_reloc) begin
      if (cand_legal(l, hx, hy)) begin
        m_ax = 7'(int'(l) % 128);
        m_ay = 7'((int'(l) / 256) % 64);
        m_reloc = 1'b0;
      end
    end else if (st == 2'b10 && hx == m_ax && hy == m_ay) begin
      m_add = 1'b1;
      m_score = bcd_next(m_score);
    end
  endtask

  function automatic logic exp_pix(input logic [9:0] xp,
                                   input logic [9:0] yp);
    return xp < 640 && yp < 480
        && int'(xp) / 8 == int'(m_ax)
        && int'(yp) / 8 == int'(m_ay) && !m_reloc;
  endfunction

  task automatic check_all(input logic [9:0] xp,
                           input logic [9:0] yp);
    chk("add_cube", 16'(food.add_cube), 16'(m_add));
    chk("apple_x", 16'(food.apple_x), 16'(m_ax));
    chk("apple_y", 16'(food.apple_y), 16'(m_ay));
    chk("score", food.score, m_score);
    chk("apple_pix", 16'(food.apple_pix), 16'(exp_pix(xp, yp)));
  endtask

  task automatic step(input logic [1:0] st,
                      input logic [6:0] hx,
                      input logic [6:0] hy,
                      input logic [9:0] xp,
                      input logic [9:0] yp);
    food.game_status = st;
    food.head_x = hx;
    food.head_y = hy;
    food.x_pos  = xp;
    food.y_pos  = yp;
    @(posedge clk);
    if (rst) model_clock(st, hx, hy);
    @(negedge clk);
    check_all(xp, yp);
  endtask

  task automatic rand_step_head(input logic [1:0] st);
    step(st, 7'($urandom_range(0, 127)),
         7'($urandom_range(0, 127)),
         10'($urandom_range(0, 1023)),
         10'($urandom_range(0, 1023)));
  endtask

  task automatic eat_once();
    int t;
    t = 0;
    while (!m_add && t < 50) begin
      step(2'b10, m_ax, m_ay, 10'd0, 10'd0);
      t++;
    end
    if (!m_add) chk("eat_timeout", 16'd0, 16'd1);
    t = 0;
    while ((m_add || m_reloc) && t < 200) begin
      rand_step_head(2'b10);
      t++;
    end
    if (m_reloc) chk("gen_timeout", 16'd0, 16'd1);
  endtask

  task automatic async_reset_now();
    rst = 1'b0;
    #1;
    chk("rst_add", 16'(food.add_cube), 16'd0);
    chk("rst_ax", 16'(food.apple_x), 16'd40);
    chk("rst_ay", 16'(food.apple_y), 16'd30);
    chk("rst_score", food.score, 16'h0000);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int pulses, width, max_w, forced, t;
    logic prev;
    logic [1:0] st;
    logic [6:0] hx, hy;
    int r, ox, oy;

    tab[0] = '{2'b10, 7'd10, 7'd25, 10'd320, 10'd240,
               1'b0, 7'd40, 7'd30, 1'b1, 16'h0};
    tab[1] = '{2'b10, 7'd10, 7'd25, 10'd327, 10'd247,
               1'b0, 7'd40, 7'd30, 1'b1, 16'h0};
    tab[2] = '{2'b10, 7'd10, 7'd25, 10'd328, 10'd240,
               1'b0, 7'd40, 7'd30, 1'b0, 16'h0};
    tab[3] = '{2'b10, 7'd10, 7'd25, 10'd319, 10'd240,
               1'b0, 7'd40, 7'd30, 1'b0, 16'h0};
    tab[4] = '{2'b10, 7'd10, 7'd25, 10'd320, 10'd248,
               1'b0, 7'd40, 7'd30, 1'b0, 16'h0};
    tab[5] = '{2'b10, 7'd10, 7'd25, 10'd324, 10'd239,
               1'b0, 7'd40, 7'd30, 1'b0, 16'h0};
    tab[6] = '{2'b01, 7'd40, 7'd30, 10'd323, 10'd244,
               1'b0, 7'd40, 7'd30, 1'b1, 16'h0};
    tab[7] = '{2'b11, 7'd40, 7'd30, 10'd0, 10'd0,
               1'b0, 7'd40, 7'd30, 1'b0, 16'h0};
    tab[8] = '{2'b10, 7'd40, 7'd29, 10'd321, 10'd246,
               1'b0, 7'd40, 7'd30, 1'b1, 16'h0};
    tab[9] = '{2'b10, 7'd39, 7'd30, 10'd640, 10'd240,
               1'b0, 7'd40, 7'd30, 1'b0, 16'h0};

    food.game_status = 2'b00;
    food.head_x = 7'd0;
    food.head_y = 7'd0;
    food.x_pos  = 10'd0;
    food.y_pos  = 10'd0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_add", 16'(food.add_cube), 16'd0);
    chk("reset_ax", 16'(food.apple_x), 16'd40);
    chk("reset_ay", 16'(food.apple_y), 16'd30);
    chk("reset_score", food.score, 16'h0000);
    rst = 1'b1;

    // directed table
    for (int i = 0; i < 10; i++) begin
      food.game_status = tab[i].st;
      food.head_x = tab[i].hx;
      food.head_y = tab[i].hy;
      food.x_pos  = tab[i].xp;
      food.y_pos  = tab[i].yp;
      @(posedge clk);
      model_clock(tab[i].st, tab[i].hx, tab[i].hy);
      @(negedge clk);
      chk($sformatf("tab%0d_add", i),
          16'(food.add_cube), 16'(tab[i].add));
      chk($sformatf("tab%0d_ax", i),
          16'(food.apple_x), 16'(tab[i].ax));
      chk($sformatf("tab%0d_ay", i),
          16'(food.apple_y), 16'(tab[i].ay));
      chk($sformatf("tab%0d_pix", i),
          16'(food.apple_pix), 16'(tab[i].pix));
      chk($sformatf("tab%0d_score", i),
          food.score, tab[i].sc);
    end

    // idle play, scanning the apple cell
    for (int i = 0; i < 100; i++) begin
      step(2'b10, 7'd10, 7'd25,
           10'(320 + i % 9), 10'(240 + (i / 9) % 9));
      if (food.add_cube) chk("idle_add", 16'd1, 16'd0);
    end

    // single eat, pulse width and relocation
    pulses = 0; width = 0; max_w = 0; prev = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(2'b10, 7'd40, 7'd30, 10'd320, 10'd240);
      if (food.add_cube && !prev) pulses++;
      width = food.add_cube ? width + 1 : 0;
      if (width > max_w) max_w = width;
      if (m_reloc)
        chk("gen_pix", 16'(food.apple_pix), 16'd0);
      prev = food.add_cube;
    end
    t = 0;
    while (m_reloc && t < 100) begin
      step(2'b10, 7'd40, 7'd30, 10'd320, 10'd240);
      t++;
    end
    chk("eat_pulses", 16'(pulses), 16'd1);
    chk("eat_width", 16'(max_w), 16'd1);
    chk("eat_score", food.score, 16'h0001);
    chk("new_apple_legal",
        16'(food.apple_x >= 1 && food.apple_x <= 75
         && food.apple_y >= 1 && food.apple_y <= 58
         && !(food.apple_x == 40 && food.apple_y == 30)),
        16'd1);

    // candidates forced equal to head, then retries
    for (int k = 0; k < 6; k++) begin
      forced = 0;
      t = 0;
      while (!m_add && t < 50) begin
        step(2'b10, m_ax, m_ay, 10'd0, 10'd0);
        t++;
      end
      t = 0;
      while ((m_add || m_reloc) && t < 200) begin
        ox = m_ax; oy = m_ay;
        if (m_reloc && forced < 2
            && cand_legal(m_lfsr, 7'd0, 7'd0)) begin
          hx = 7'(int'(m_lfsr) % 128);
          hy = 7'((int'(m_lfsr) / 256) % 64);
          forced++;
          step(2'b10, hx, hy, 10'd0, 10'd0);
          chk("forced_retry_ax", 16'(food.apple_x), 16'(ox));
          chk("forced_retry_ay", 16'(food.apple_y), 16'(oy));
        end else begin
          rand_step_head(2'b10);
        end
        t++;
      end
      if (m_reloc) chk("forced_gen_timeout", 16'd0, 16'd1);
    end

    // BCD carry 0099 -> 0100
    t = 0;
    while (m_score != 16'h0099 && t < 200) begin
      eat_once();
      t++;
    end
    chk("score_0099", food.score, 16'h0099);
    eat_once();
    chk("score_0100", food.score, 16'h0100);

    // saturation at 9999
    t = 0;
    while (m_score != 16'h9999 && t < 11000) begin
      eat_once();
      t++;
    end
    chk("score_9999", food.score, 16'h9999);
    t = 0;
    pulses = 0;
    while (!m_add && t < 50) begin
      step(2'b10, m_ax, m_ay, 10'd0, 10'd0);
      t++;
    end
    if (food.add_cube) pulses++;
    chk("sat_pulse", 16'(pulses), 16'd1);
    chk("sat_score", food.score, 16'h9999);
    t = 0;
    while ((m_add || m_reloc) && t < 200) begin
      rand_step_head(2'b10);
      t++;
    end

    // RESTART during GEN
    t = 0;
    while (!m_reloc && t < 60) begin
      step(2'b10, m_ax, m_ay, 10'd0, 10'd0);
      t++;
    end
    step(2'b00, 7'd5, 7'd5, 10'd320, 10'd240);
    chk("rs_gen_ax", 16'(food.apple_x), 16'd40);
    chk("rs_gen_ay", 16'(food.apple_y), 16'd30);
    chk("rs_gen_score", food.score, 16'h0000);
    chk("rs_gen_add", 16'(food.add_cube), 16'd0);
    chk("rs_gen_pix", 16'(food.apple_pix), 16'd1);
    for (int i = 0; i < 4; i++) begin
      step(2'b10, 7'd5, 7'd5, 10'd0, 10'd0);
      chk("rs_after_add", 16'(food.add_cube), 16'd0);
    end

    // reset mid-EAT and mid-GEN
    t = 0;
    while (!m_add && t < 50) begin
      step(2'b10, m_ax, m_ay, 10'd0, 10'd0);
      t++;
    end
    async_reset_now();
    step(2'b10, 7'd40, 7'd30, 10'd0, 10'd0);
    chk("rst_eat_noadd", 16'(food.add_cube), 16'd0);
    t = 0;
    while (!m_reloc && t < 60) begin
      step(2'b10, m_ax, m_ay, 10'd0, 10'd0);
      t++;
    end
    async_reset_now();
    step(2'b10, 7'd1, 7'd1, 10'd0, 10'd0);

    // random play
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      st = r < 85 ? 2'b10 : r < 90 ? 2'b00
         : r < 95 ? 2'b01 : 2'b11;
      if ($urandom_range(0, 9) < 4) begin
        hx = m_ax; hy = m_ay;
      end else begin
        hx = 7'($urandom_range(0, 127));
        hy = 7'($urandom_range(0, 127));
      end
      if ($urandom_range(0, 499) == 0) begin
        async_reset_now();
      end else if ($urandom_range(0, 1) == 1) begin
        step(st, hx, hy,
             10'(int'(m_ax) * 8 + $urandom_range(0, 9) - 1),
             10'(int'(m_ay) * 8 + $urandom_range(0, 9) - 1));
      end else begin
        step(st, hx, hy,
             10'($urandom_range(0, 1023)),
             10'($urandom_range(0, 1023)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
